// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes,
// memory-wait freeze, plus saturating stall/flush performance counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal flow; detects load-use hazards and taken branches
// ST_STALL | extra load-use bubble cycles beyond the first
// ST_FLUSH | extra IF/ID + ID/EX flush cycles after a taken branch
// (2'b11)  | unreachable; decoded as ST_RUN
module pipe_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             mem_read_e,
    input  logic             branch_taken_e,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // count only ever holds up to (cycles - 1), so clog2(max) bits suffice
    localparam int MAXC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign freeze   = !imem_ready || !dmem_ready;
    assign load_use = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Next-state and pipeline controls; reset and freeze force everything idle
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;

        if (!rst || freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (branch_taken_e) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                count_d = CW'(FLUSH_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
                count_d = '0;
            end
        end else begin
            case (state_q)
                ST_STALL: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                    if (count_q == CW'(1)) begin
                        state_d = ST_RUN;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
                ST_FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (count_q == CW'(1)) begin
                        state_d = ST_RUN;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = ST_STALL;
                            count_d = CW'(STALL_CYCLES - 1);
                        end
                    end
                end
            endcase
        end
    end

    // Saturating counters; clear wins over a same-cycle increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, count and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            count_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state_o   = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with STALL_CYCLES=2, FLUSH_CYCLES=3,
// CNT_W=4. Each step queues its expected outputs; a monitor checks them.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_e;
    logic       mem_read_e, branch_taken_e, imem_ready, dmem_ready, perf_clr;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic [1:0] state_o;
    logic [3:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(
        .REG_W(5), .STALL_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
        .mem_read_e(mem_read_e), .branch_taken_e(branch_taken_e),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    localparam logic [6:0] C_RUN   = 7'b1101011;
    localparam logic [6:0] C_STALL = 7'b0001111;
    localparam logic [6:0] C_FLUSH = 7'b1111111;
    localparam logic [6:0] C_ZERO  = 7'b0000000;

    typedef struct {
        logic [6:0] ctl;
        logic [1:0] st;
        logic [3:0] sc;
        logic [3:0] fc;
        int         id;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    // Monitor: outputs are presented every cycle; compare at the falling edge
    always @(negedge clk) begin
        exp_t e;
        logic [6:0] ctl;
        if (q.size() > 0) begin
            e   = q.pop_front();
            ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
            total++;
            if (ctl !== e.ctl) begin
                bad++;
                $display("FAIL step%0d ctl got=%b exp=%b", e.id, ctl, e.ctl);
            end
            total++;
            if (state_o !== e.st) begin
                bad++;
                $display("FAIL step%0d state got=%b exp=%b", e.id, state_o, e.st);
            end
            total++;
            if (stall_cnt !== e.sc) begin
                bad++;
                $display("FAIL step%0d stall_cnt got=%0d exp=%0d", e.id, stall_cnt, e.sc);
            end
            total++;
            if (flush_cnt !== e.fc) begin
                bad++;
                $display("FAIL step%0d flush_cnt got=%0d exp=%0d", e.id, flush_cnt, e.fc);
            end
        end
    end

    // Drive one cycle of inputs (just after a rising edge) and queue its expectation
    task automatic step(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic mr, input logic br,
                        input logic im, input logic dm, input logic clr,
                        input logic [6:0] ctl, input logic [1:0] st,
                        input int sc, input int fc);
        exp_t e;
        rst = r; rs1_d = s1; rs2_d = s2; rd_e = d;
        mem_read_e = mr; branch_taken_e = br;
        imem_ready = im; dmem_ready = dm; perf_clr = clr;
        e.ctl = ctl; e.st = st; e.sc = 4'(sc); e.fc = 4'(fc); e.id = step_id;
        q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    // neutral: no hazard, no branch, memories ready
    task automatic idle(input logic [6:0] ctl, input logic [1:0] st, input int sc, input int fc);
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ctl, st, sc, fc);
    endtask

    initial begin
        int s;
        rst = 1'b0; rs1_d = 5'd1; rs2_d = 5'd2; rd_e = 5'd3;
        mem_read_e = 1'b0; branch_taken_e = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1; perf_clr = 1'b0;
        @(posedge clk);
        #1;
        // reset held: everything idle
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ZERO, 2'd0, 0, 0);
        // no-hazard load, then x0 destination
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_RUN, 2'd0, 0, 0);
        step(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_RUN, 2'd0, 0, 0);
        // load-use on rs1: two stall cycles, RUN->STALL->RUN
        step(1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_STALL, 2'd0, 0, 0);
        idle(C_STALL, 2'd1, 1, 0);
        idle(C_RUN, 2'd0, 2, 0);
        // branch with simultaneous load-use on rs2: branch wins, 3 flush cycles
        step(1'b1, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_FLUSH, 2'd0, 2, 0);
        idle(C_FLUSH, 2'd2, 2, 1);
        idle(C_FLUSH, 2'd2, 2, 1);
        idle(C_RUN, 2'd0, 2, 1);
        // dmem freeze for 4 cycles inside STALL with count 1
        step(1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_STALL, 2'd0, 2, 1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_ZERO, 2'd1, 3, 1);
        idle(C_STALL, 2'd1, 3, 1);
        idle(C_RUN, 2'd0, 4, 1);
        // imem freeze masks a branch
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_ZERO, 2'd0, 4, 1);
        idle(C_RUN, 2'd0, 4, 1);
        // branch aborts a stall, then a second branch reloads the flush count
        step(1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_STALL, 2'd0, 4, 1);
        step(1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_FLUSH, 2'd1, 5, 1);
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_FLUSH, 2'd2, 5, 2);
        idle(C_FLUSH, 2'd2, 5, 3);
        idle(C_FLUSH, 2'd2, 5, 3);
        idle(C_RUN, 2'd0, 5, 3);
        // perf_clr honoured during freeze
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_ZERO, 2'd0, 5, 3);
        idle(C_RUN, 2'd0, 0, 0);
        // 20 load-use events: stall_cnt saturates at 15
        s = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_STALL, 2'd0, s, 0);
            idle(C_STALL, 2'd1, (s + 1 > 15) ? 15 : s + 1, 0);
            s = (s + 2 > 15) ? 15 : s + 2;
        end
        idle(C_RUN, 2'd0, 15, 0);
        // clear overrides a same-cycle increment
        step(1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, C_STALL, 2'd0, 15, 0);
        idle(C_STALL, 2'd1, 0, 0);
        idle(C_RUN, 2'd0, 1, 0);
        // async reset mid-FLUSH with count 2
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_FLUSH, 2'd0, 1, 0);
        step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ZERO, 2'd0, 0, 0);
        idle(C_RUN, 2'd0, 0, 0);
        idle(C_RUN, 2'd0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
